// File: rtl/tx_shift_datapath.sv
// UART transmit shift datapath: builds a start/data/parity/stop frame on load and
// shifts it out LSB-first at CLKS_PER_BIT clocks per bit while shift_en is high.
module tx_shift_datapath #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              done,
    output logic              busy
);

    localparam int unsigned FRAME_W = 1 + DATA_W + PARITY_EN + STOP_BITS;
    localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] r_shreg;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [BAUD_W-1:0]  r_baud_cnt;
    logic               r_tx;
    logic               r_done;
    logic               r_busy;

    logic [FRAME_W-1:0] w_frame;
    logic               w_parity;

    // Stop bits fill the top by defaulting the whole frame to ones.
    always_comb begin
        w_parity           = (PARITY_ODD != 0) ? ~^data_in : ^data_in;
        w_frame            = '1;
        w_frame[DATA_W:1]  = data_in;
        w_frame[0]         = 1'b0;
        if (PARITY_EN != 0) begin
            w_frame[DATA_W+1] = w_parity;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg    <= '1;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else if (load) begin
            r_shreg    <= w_frame;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
        end else if (r_busy && shift_en) begin
            if (r_baud_cnt == BAUD_LAST) begin
                r_baud_cnt <= '0;
                r_shreg    <= {1'b1, r_shreg[FRAME_W-1:1]};
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                // Last stop bit has now served its full bit time.
                if (r_bit_cnt == BIT_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_tx   <= 1'b1;
                end else begin
                    r_tx   <= r_shreg[1];
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
        end
    end

    assign tx   = r_tx;
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: tb/tb_tx_shift_datapath.sv
// Self-checking bench for tx_shift_datapath: four parameter variants share stimulus,
// expected tx bits are queued at load time and popped as the frame advances.
module tb_tx_shift_datapath;

    localparam int CPB = 4;
    localparam int PE   [4] = '{0, 1, 1, 0};
    localparam int ODD  [4] = '{0, 0, 1, 0};
    localparam int STOP [4] = '{1, 1, 1, 2};

    logic       clk;
    logic       rst;
    logic       load;
    logic       shift_en;
    logic [7:0] data_in;
    logic [3:0] tx_v;
    logic [3:0] done_v;
    logic [3:0] busy_v;

    int n_err = 0;
    int n_chk = 0;
    logic exp_q[$];

    tx_shift_datapath #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                        .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .load(load), .shift_en(shift_en), .data_in(data_in),
        .tx(tx_v[0]), .done(done_v[0]), .busy(busy_v[0]));
    tx_shift_datapath #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0),
                        .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .load(load), .shift_en(shift_en), .data_in(data_in),
        .tx(tx_v[1]), .done(done_v[1]), .busy(busy_v[1]));
    tx_shift_datapath #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1),
                        .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .load(load), .shift_en(shift_en), .data_in(data_in),
        .tx(tx_v[2]), .done(done_v[2]), .busy(busy_v[2]));
    tx_shift_datapath #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                        .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .load(load), .shift_en(shift_en), .data_in(data_in),
        .tx(tx_v[3]), .done(done_v[3]), .busy(busy_v[3]));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    function automatic logic [2:0] obs(input int idx);
        return {busy_v[idx], done_v[idx], tx_v[idx]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: start, data LSB-first, optional parity, stop bits; CPB cycles each.
    task automatic push_frame(input logic [7:0] d, input int idx);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PE[idx] != 0) bits.push_back((ODD[idx] != 0) ? ~^d : ^d);
        for (int i = 0; i < STOP[idx]; i++) bits.push_back(1'b1);
        foreach (bits[b]) for (int c = 0; c < CPB; c++) exp_q.push_back(bits[b]);
    endtask

    task automatic do_load(input logic [7:0] d, input int idx);
        load    = 1'b1;
        data_in = d;
        push_frame(d, idx);
        step();
        load    = 1'b0;
        data_in = ~d;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        load     = 1'b0;
        shift_en = 1'b0;
        step();
        step();
        rst      = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        load     = 1'b1;
        shift_en = 1'b1;
        data_in  = 8'h55;
        step();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (obs(i) !== 3'b001) begin
                n_err++;
                $display("FAIL reset dut%0d: busy,done,tx=%b want 001", i, obs(i));
            end
        end
        load = 1'b0;
        rst  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_chk++;
            if (obs(0) !== 3'b001) begin
                n_err++;
                $display("FAIL idle_shift cycle %0d: busy,done,tx=%b want 001", c, obs(0));
            end
        end
    endtask

    task automatic test_frame(input int idx, input logic [7:0] d, input int exp_done);
        int k;
        apply_reset();
        do_load(d, idx);
        shift_en = 1'b1;
        k = 1;
        while (exp_q.size() > 0 && k < 200) begin
            n_chk++;
            if (obs(idx) !== {2'b10, exp_q[0]}) begin
                n_err++;
                $display("FAIL frame dut%0d data=%h cycle %0d: busy,done,tx=%b want %b",
                         idx, d, k, obs(idx), {2'b10, exp_q[0]});
            end
            void'(exp_q.pop_front());
            step();
            k++;
        end
        n_chk++;
        if (obs(idx) !== 3'b011 || k != exp_done) begin
            n_err++;
            $display("FAIL frame_done dut%0d: busy,done,tx=%b at L+%0d want 011 at L+%0d",
                     idx, obs(idx), k, exp_done);
        end
    endtask

    task automatic test_pause();
        int k;
        apply_reset();
        do_load(8'hA5, 0);
        k = 1;
        while (exp_q.size() > 0 && k < 200) begin
            shift_en = !(k >= 18 && k < 28);
            n_chk++;
            if (obs(0) !== {2'b10, exp_q[0]}) begin
                n_err++;
                $display("FAIL pause cycle %0d: busy,done,tx=%b want %b",
                         k, obs(0), {2'b10, exp_q[0]});
            end
            if (shift_en) void'(exp_q.pop_front());
            step();
            k++;
        end
        n_chk++;
        if (obs(0) !== 3'b011 || k != 51) begin
            n_err++;
            $display("FAIL pause_done: busy,done,tx=%b at L+%0d want 011 at L+51", obs(0), k);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        do_load(8'hA5, 0);
        shift_en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            n_chk++;
            if (obs(0) !== {2'b10, exp_q[0]}) begin
                n_err++;
                $display("FAIL pre_reset cycle %0d: busy,done,tx=%b want %b",
                         k, obs(0), {2'b10, exp_q[0]});
            end
            void'(exp_q.pop_front());
            if (k == 15) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 8; c++) begin
            shift_en = c[0];
            n_chk++;
            if (obs(0) !== 3'b001) begin
                n_err++;
                $display("FAIL post_reset cycle %0d: busy,done,tx=%b want 001", c, obs(0));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int k;
        apply_reset();
        do_load(8'hA5, 0);
        shift_en = 1'b1;
        k = 1;
        while (exp_q.size() > 0 && k < 200) begin
            n_chk++;
            if (obs(0) !== {2'b10, exp_q[0]}) begin
                n_err++;
                $display("FAIL reload cycle %0d: busy,done,tx=%b want %b",
                         k, obs(0), {2'b10, exp_q[0]});
            end
            if (k == 20) begin
                exp_q.delete();
                load    = 1'b1;
                data_in = 8'h3C;
                push_frame(8'h3C, 0);
            end else begin
                void'(exp_q.pop_front());
            end
            step();
            load    = 1'b0;
            data_in = 8'h00;
            k++;
        end
        n_chk++;
        if (obs(0) !== 3'b011 || k != 61) begin
            n_err++;
            $display("FAIL reload_done: busy,done,tx=%b at L+%0d want 011 at L+61", obs(0), k);
        end
    endtask

    task automatic test_closed_loop();
        int k;
        logic [7:0] d;
        apply_reset();
        for (int rep = 0; rep < 2; rep++) begin
            d = (rep == 0) ? 8'hC3 : 8'h81;
            do_load(d, 0);
            shift_en = 1'b1;
            k = 1;
            while (exp_q.size() > 0 && k < 200) begin
                n_chk++;
                if (obs(0) !== {2'b10, exp_q[0]}) begin
                    n_err++;
                    $display("FAIL loop%0d cycle %0d: busy,done,tx=%b want %b",
                             rep, k, obs(0), {2'b10, exp_q[0]});
                end
                void'(exp_q.pop_front());
                step();
                k++;
            end
            // Controller sees done this cycle and drops shift_en on the next.
            while (k < 50) begin
                n_chk++;
                if (obs(0) !== 3'b011 || k < 41) begin
                    n_err++;
                    $display("FAIL loop%0d idle cycle %0d: busy,done,tx=%b want 011",
                             rep, k, obs(0));
                end
                step();
                shift_en = 1'b0;
                k++;
            end
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        load     = 1'b0;
        shift_en = 1'b0;
        data_in  = 8'h00;
        test_reset();
        test_frame(0, 8'hA5, 41);
        test_frame(1, 8'h07, 45);
        test_frame(2, 8'h07, 45);
        test_frame(3, 8'h5A, 45);
        test_pause();
        test_mid_reset();
        test_back_to_back();
        test_closed_loop();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
